color_check_ctrl: RTL and testbench
===================================

Name: color_check_ctrl

Overview:
- Hardware sequencer that walks the graph stored in the 256x8 data memory and checks the node colouring. Per node: index table -> adjacency list -> colour slots.
- Shares the memory's single port with the CPU; the CPU has strict priority and the checker stalls while the CPU holds the port.
- Reports first conflict or uncoloured-node count, and writes a status byte back into memory.

Parameters:
- N_NODES, 33, number of graph nodes (node ids 0..N_NODES-1).
- IDX_BASE, 148, address of index table; idx[n] = start pointer of node n's adjacency list.
- END_PTR_ADDR, 255, address holding end pointer of the last node's list.
- COLOR_BASE, 181, address of colour slot for node 0; 0 = uncoloured.
- STATUS_ADDR, 254, address where the result byte is written.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  one-cycle request to begin a check; sampled only in IDLE
- abort  in  1  return to IDLE next cycle; no status write, no done
- cpu_req  in  1  CPU wants the memory port this cycle
- cpu_we  in  1  CPU write enable, qualified by cpu_req
- cpu_addr  in  8  CPU address
- cpu_wdata  in  8  CPU write data
- cpu_gnt  out  1  equals cpu_req (combinational)
- mem_we  out  1  to memory we
- mem_addr  out  8  to memory addr
- mem_in  out  8  to memory in
- mem_out  in  8  memory asynchronous read data
- busy  out  1  checker active
- done  out  1  one-cycle pulse, result valid
- conflict  out  1  sticky until next start: a conflict was found
- conflict_node  out  8  node id of the conflict
- conflict_nbr  out  8  neighbour id of the conflict
- uncolored  out  8  count of nodes with colour 0

Behaviour:
- Reset (rst_n=0 at a clk edge): state IDLE. busy, done, conflict, conflict_node, conflict_nbr and uncolored all 0. Mid-run reset aborts with no memory write.
- Port mux:
  - cpu_req=1: mem_addr=cpu_addr, mem_in=cpu_wdata, mem_we=cpu_we, and the checker FSM holds state and all registers.
  - cpu_req=0: the checker drives the port. mem_we=1 only in WR_STAT.
- One memory read per cycle: the FSM drives mem_addr and captures mem_out at the same clk edge.
- States and transitions (each listed transition consumes one unstalled cycle):
  - IDLE: start=1 clears conflict, conflict_node, conflict_nbr and uncolored; sets n=0 -> RD_LO. start while not IDLE is ignored.
  - RD_LO: addr IDX_BASE+n; ptr<=mem_out -> RD_HI.
  - RD_HI: addr IDX_BASE+n+1, or END_PTR_ADDR when n=N_NODES-1; hi<=mem_out -> RD_MY.
  - RD_MY: addr COLOR_BASE+n; mycol<=mem_out; if mem_out==0, uncolored+=1. Then RD_ADJ if ptr<hi (unsigned); else next-node.
  - RD_ADJ: addr ptr; nb<=mem_out; ptr+=1. If mem_out>=N_NODES, skip it: RD_ADJ if ptr+1<hi, else next-node. Otherwise -> RD_NCOL.
  - RD_NCOL: addr COLOR_BASE+nb. If mycol!=0 and mem_out==mycol: conflict<=1, conflict_node<=n, conflict_nbr<=nb -> WR_STAT. Otherwise RD_ADJ if ptr<hi, else next-node.
  - next-node: n+=1 -> RD_LO; if n was N_NODES-1 -> WR_STAT.
  - WR_STAT: write status byte to STATUS_ADDR -> IDLE, with done=1 in the following cycle.
- Status byte: conflict ? {1'b1, conflict_node[6:0]} : {1'b0, uncolored[6:0]}.
- busy=1 in every state except IDLE.
- Result outputs hold their values after done until the next accepted start.
- Width rules: addresses are 8-bit and wrap mod 256. uncolored saturates at 255.
- abort takes priority over start/FSM progress (not over cpu_req muxing). Effect: IDLE next cycle, busy=0, results keep their partial values.
- Cycle cost with no stalls: sum over nodes of (3 + 2*k_valid + k_skipped), plus 1 for WR_STAT.

Test Plan:
- Reset image, all colours 0, start, no CPU traffic -> done after 394 busy cycles; conflict=0, uncolored=33; mem[254]=8'h21.
- CPU writes mem[181]=1 and mem[182]=1, then start -> conflict at node 0 (neighbour 1) after 6 busy cycles; conflict_node=0, conflict_nbr=1, mem[254]=8'h80.
- As the first scenario, with cpu_req held 10 cycles mid-run (reads only) -> cpu_gnt=1 and mem_addr=cpu_addr during those cycles; done after 404 busy cycles; identical results.
- Set mem[149]=0 so idx[1]=idx[0] (node 0 has an empty list) -> node 0 costs 3 cycles; no read of address 0 for node 0; run completes without error.
- Set mem[0]=40 (out-of-range neighbour) and colour mem[181]=2 -> entry skipped with no read of COLOR_BASE+40; no conflict from node 0.
- Assert abort 20 cycles into a run -> busy=0 next cycle, no done, mem[254] unchanged. A following start runs a full check normally; start pulses during busy are ignored.

Source files
------------

// File: rtl/color_check_ctrl.sv
// color_check_ctrl: walks the graph held in a shared 256x8 single-port memory
// and checks the node colouring. For each node it reads the node's two index
// entries, its own colour, then every adjacency entry and that neighbour's colour.
// It reports the first conflict or the number of uncoloured nodes, and writes a
// status byte back into memory.
//
// Port sharing: cpu_req is a request that is always granted in the same cycle
// (cpu_gnt = cpu_req). While it is high, the CPU owns mem_addr/mem_in/mem_we and
// the checker freezes. There is no back-pressure on the CPU side.
module color_check_ctrl #(
   parameter int N_NODES      = 33,
   parameter int IDX_BASE     = 148,
   parameter int END_PTR_ADDR = 255,
   parameter int COLOR_BASE   = 181,
   parameter int STATUS_ADDR  = 254
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       abort,
   input  logic       cpu_req,
   input  logic       cpu_we,
   input  logic [7:0] cpu_addr,
   input  logic [7:0] cpu_wdata,
   output logic       cpu_gnt,
   output logic       mem_we,
   output logic [7:0] mem_addr,
   output logic [7:0] mem_in,
   input  logic [7:0] mem_out,
   output logic       busy,
   output logic       done,
   output logic       conflict,
   output logic [7:0] conflict_node,
   output logic [7:0] conflict_nbr,
   output logic [7:0] uncolored
);

   localparam logic [7:0] LAST_N   = 8'(N_NODES - 1);
   localparam logic [7:0] NN       = 8'(N_NODES);
   localparam logic [7:0] IDX_B    = 8'(IDX_BASE);
   localparam logic [7:0] END_A    = 8'(END_PTR_ADDR);
   localparam logic [7:0] COL_B    = 8'(COLOR_BASE);
   localparam logic [7:0] STAT_A   = 8'(STATUS_ADDR);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD_LO   = 3'd1,
      RD_HI   = 3'd2,
      RD_MY   = 3'd3,
      RD_ADJ  = 3'd4,
      RD_NCOL = 3'd5,
      WR_STAT = 3'd6
   } state_t;

   state_t     state, state_d;
   logic [7:0] n, n_d;
   logic [7:0] ptr, ptr_d;
   logic [7:0] hi, hi_d;
   logic [7:0] mycol, mycol_d;
   logic [7:0] nb, nb_d;
   logic       conflict_d;
   logic [7:0] conflict_node_d, conflict_nbr_d, uncolored_d;
   logic       done_d;
   logic       go_next;
   logic [7:0] ptr_inc;
   logic [7:0] chk_addr;
   logic       chk_we;
   logic [7:0] status_byte;

   assign ptr_inc     = ptr + 8'd1;
   assign status_byte = conflict ? {1'b1, conflict_node[6:0]} : {1'b0, uncolored[6:0]};
   assign busy        = (state != IDLE);
   assign cpu_gnt     = cpu_req;

   // Port mux: the CPU always wins the memory port.
   always_comb begin
      mem_addr = cpu_req ? cpu_addr  : chk_addr;
      mem_in   = cpu_req ? cpu_wdata : status_byte;
      mem_we   = cpu_req ? cpu_we    : chk_we;
   end

   // Next-state logic: one memory read per state, captured at the same edge.
   always_comb begin
      state_d         = state;
      n_d             = n;
      ptr_d           = ptr;
      hi_d            = hi;
      mycol_d         = mycol;
      nb_d            = nb;
      conflict_d      = conflict;
      conflict_node_d = conflict_node;
      conflict_nbr_d  = conflict_nbr;
      uncolored_d     = uncolored;
      done_d          = 1'b0;
      go_next         = 1'b0;
      chk_addr        = 8'h00;
      chk_we          = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               conflict_d      = 1'b0;
               conflict_node_d = 8'h00;
               conflict_nbr_d  = 8'h00;
               uncolored_d     = 8'h00;
               n_d             = 8'h00;
               state_d         = RD_LO;
            end
         end
         RD_LO: begin
            chk_addr = IDX_B + n;
            ptr_d    = mem_out;
            state_d  = RD_HI;
         end
         RD_HI: begin
            chk_addr = (n == LAST_N) ? END_A : (IDX_B + n + 8'd1);
            hi_d     = mem_out;
            state_d  = RD_MY;
         end
         RD_MY: begin
            chk_addr = COL_B + n;
            mycol_d  = mem_out;
            if (mem_out == 8'h00 && uncolored != 8'hFF) uncolored_d = uncolored + 8'd1;
            if (ptr < hi) state_d = RD_ADJ;
            else          go_next = 1'b1;
         end
         RD_ADJ: begin
            chk_addr = ptr;
            nb_d     = mem_out;
            ptr_d    = ptr_inc;
            if (mem_out >= NN) begin
               // Out-of-range neighbour id: skip without reading its colour.
               if (ptr_inc < hi) state_d = RD_ADJ;
               else              go_next = 1'b1;
            end else begin
               state_d = RD_NCOL;
            end
         end
         RD_NCOL: begin
            chk_addr = COL_B + nb;
            if (mycol != 8'h00 && mem_out == mycol) begin
               conflict_d      = 1'b1;
               conflict_node_d = n;
               conflict_nbr_d  = nb;
               state_d         = WR_STAT;
            end else if (ptr < hi) begin
               state_d = RD_ADJ;
            end else begin
               go_next = 1'b1;
            end
         end
         WR_STAT: begin
            chk_addr = STAT_A;
            chk_we   = !abort;
            done_d   = 1'b1;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (go_next) begin
         if (n == LAST_N) begin
            state_d = WR_STAT;
         end else begin
            n_d     = n + 8'd1;
            state_d = RD_LO;
         end
      end
   end

   // State register: abort beats progress, a CPU cycle freezes everything.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= IDLE;
         n             <= 8'h00;
         ptr           <= 8'h00;
         hi            <= 8'h00;
         mycol         <= 8'h00;
         nb            <= 8'h00;
         conflict      <= 1'b0;
         conflict_node <= 8'h00;
         conflict_nbr  <= 8'h00;
         uncolored     <= 8'h00;
         done          <= 1'b0;
      end else if (abort) begin
         state <= IDLE;
         done  <= 1'b0;
      end else if (cpu_req) begin
         done  <= 1'b0;
      end else begin
         state         <= state_d;
         n             <= n_d;
         ptr           <= ptr_d;
         hi            <= hi_d;
         mycol         <= mycol_d;
         nb            <= nb_d;
         conflict      <= conflict_d;
         conflict_node <= conflict_node_d;
         conflict_nbr  <= conflict_nbr_d;
         uncolored     <= uncolored_d;
         done          <= done_d;
      end
   end

endmodule

// File: tb/tb_color_check_ctrl.sv
// Directed bench for color_check_ctrl with a behavioural 256x8 memory.
// Graph image: 33 nodes, nodes 0..14 have 5 neighbours, 15..32 have 4;
// node n's j-th neighbour is (n+1+j) mod 33. Lists occupy addresses 0..146.
module tb_color_check_ctrl;

   logic       clk = 1'b0;
   logic       rst_n, start, abort, cpu_req, cpu_we;
   logic [7:0] cpu_addr, cpu_wdata;
   logic       cpu_gnt, mem_we;
   logic [7:0] mem_addr, mem_in, mem_out;
   logic       busy, done, conflict;
   logic [7:0] conflict_node, conflict_nbr, uncolored;

   logic [7:0] mem [256];
   int n_checks = 0;
   int n_fail   = 0;

   logic       mon_clr;
   int         busy_cnt, done_seen, bad_read, log_n;
   logic [7:0] addr_log [4];

   always #5 clk = ~clk;

   color_check_ctrl dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_gnt(cpu_gnt), .mem_we(mem_we), .mem_addr(mem_addr), .mem_in(mem_in),
      .mem_out(mem_out), .busy(busy), .done(done), .conflict(conflict),
      .conflict_node(conflict_node), .conflict_nbr(conflict_nbr), .uncolored(uncolored)
   );

   // Memory: asynchronous read, synchronous write.
   assign mem_out = mem[mem_addr];
   always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_in;

   // Monitor, sampled on the falling edge.
   always @(negedge clk) begin
      if (mon_clr) begin
         busy_cnt = 0; done_seen = 0; bad_read = 0; log_n = 0;
      end else begin
         if (busy) busy_cnt++;
         if (done) done_seen++;
         if (busy && !cpu_req && mem_addr == 8'd221) bad_read++;
         if (busy && log_n < 4) begin
            addr_log[log_n] = mem_addr;
            log_n++;
         end
      end
   end

   function automatic logic [7:0] img(input int a);
      int nd, j;
      if (a < 147) begin
         nd = (a < 75) ? a / 5 : 15 + (a - 75) / 4;
         j  = (a < 75) ? a % 5 : (a - 75) % 4;
         return 8'((nd + 1 + j) % 33);
      end else if (a >= 148 && a <= 180) begin
         nd = a - 148;
         return 8'((nd < 15) ? 5 * nd : 75 + 4 * (nd - 15));
      end else if (a == 255) begin
         return 8'd147;
      end
      return 8'd0;
   endfunction

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic cpu_write(input logic [7:0] a, input logic [7:0] d);
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_wdata = d;
      tick();
      cpu_req = 1'b0; cpu_we = 1'b0;
   endtask

   task automatic load_image();
      for (int a = 0; a < 256; a++) cpu_write(8'(a), img(a));
   endtask

   task automatic start_pulse();
      start = 1'b1; mon_clr = 1'b1;
      tick();
      start = 1'b0; mon_clr = 1'b0;
   endtask

   task automatic wait_done(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (done) begin ok = 1'b1; break; end
      end
      tick();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) tick();
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b exp 0", done); end
      n_checks++; if (conflict !== 1'b0) begin n_fail++; $display("FAIL reset_conflict got %b exp 0", conflict); end
      n_checks++; if (conflict_node !== 8'h00 || conflict_nbr !== 8'h00) begin n_fail++; $display("FAIL reset_conf_ids got %h/%h exp 00/00", conflict_node, conflict_nbr); end
      n_checks++; if (uncolored !== 8'h00) begin n_fail++; $display("FAIL reset_uncolored got %h exp 00", uncolored); end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_all_uncolored();
      bit ok;
      load_image();
      start_pulse();
      wait_done(1000, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL uncol_timeout got no done exp done"); end
      n_checks++; if (busy_cnt !== 394) begin n_fail++; $display("FAIL uncol_cycles got %0d exp 394", busy_cnt); end
      n_checks++; if (conflict !== 1'b0) begin n_fail++; $display("FAIL uncol_conflict got %b exp 0", conflict); end
      n_checks++; if (uncolored !== 8'd33) begin n_fail++; $display("FAIL uncol_count got %0d exp 33", uncolored); end
      n_checks++; if (mem[254] !== 8'h21) begin n_fail++; $display("FAIL uncol_status got %h exp 21", mem[254]); end
      n_checks++; if (done_seen !== 1) begin n_fail++; $display("FAIL uncol_done_pulses got %0d exp 1", done_seen); end
   endtask

   task automatic test_conflict();
      bit ok;
      load_image();
      cpu_write(8'd181, 8'd1);
      cpu_write(8'd182, 8'd1);
      start_pulse();
      wait_done(1000, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL conf_timeout got no done exp done"); end
      n_checks++; if (busy_cnt !== 6) begin n_fail++; $display("FAIL conf_cycles got %0d exp 6", busy_cnt); end
      n_checks++; if (conflict !== 1'b1) begin n_fail++; $display("FAIL conf_flag got %b exp 1", conflict); end
      n_checks++; if (conflict_node !== 8'd0) begin n_fail++; $display("FAIL conf_node got %0d exp 0", conflict_node); end
      n_checks++; if (conflict_nbr !== 8'd1) begin n_fail++; $display("FAIL conf_nbr got %0d exp 1", conflict_nbr); end
      n_checks++; if (uncolored !== 8'd0) begin n_fail++; $display("FAIL conf_uncol got %0d exp 0", uncolored); end
      n_checks++; if (mem[254] !== 8'h80) begin n_fail++; $display("FAIL conf_status got %h exp 80", mem[254]); end
   endtask

   task automatic test_cpu_stall();
      bit ok;
      load_image();
      start_pulse();
      repeat (50) tick();
      for (int i = 0; i < 10; i++) begin
         cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'(10 + 7 * i);
         #1;
         n_checks++; if (cpu_gnt !== 1'b1) begin n_fail++; $display("FAIL stall_gnt got %b exp 1", cpu_gnt); end
         n_checks++; if (mem_addr !== cpu_addr) begin n_fail++; $display("FAIL stall_addr got %h exp %h", mem_addr, cpu_addr); end
         n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL stall_we got %b exp 0", mem_we); end
         tick();
      end
      cpu_req = 1'b0;
      n_checks++; if (cpu_gnt !== 1'b0) begin n_fail++; $display("FAIL stall_gnt_release got %b exp 0", cpu_gnt); end
      wait_done(1000, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL stall_timeout got no done exp done"); end
      n_checks++; if (busy_cnt !== 404) begin n_fail++; $display("FAIL stall_cycles got %0d exp 404", busy_cnt); end
      n_checks++; if (uncolored !== 8'd33 || conflict !== 1'b0) begin n_fail++; $display("FAIL stall_result got %0d/%b exp 33/0", uncolored, conflict); end
      n_checks++; if (mem[254] !== 8'h21) begin n_fail++; $display("FAIL stall_status got %h exp 21", mem[254]); end
   endtask

   task automatic test_empty_list();
      bit ok;
      logic [7:0] exp_addr [4];
      exp_addr[0] = 8'd148; exp_addr[1] = 8'd149; exp_addr[2] = 8'd181; exp_addr[3] = 8'd149;
      load_image();
      cpu_write(8'd149, 8'd0);
      start_pulse();
      wait_done(1000, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL empty_timeout got no done exp done"); end
      for (int i = 0; i < 4; i++) begin
         n_checks++; if (addr_log[i] !== exp_addr[i]) begin n_fail++; $display("FAIL empty_addr%0d got %0d exp %0d", i, addr_log[i], exp_addr[i]); end
      end
      n_checks++; if (busy_cnt !== 394) begin n_fail++; $display("FAIL empty_cycles got %0d exp 394", busy_cnt); end
      n_checks++; if (mem[254] !== 8'h21) begin n_fail++; $display("FAIL empty_status got %h exp 21", mem[254]); end
   endtask

   task automatic test_out_of_range();
      bit ok;
      load_image();
      cpu_write(8'd0, 8'd40);
      cpu_write(8'd181, 8'd2);
      start_pulse();
      wait_done(1000, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL oor_timeout got no done exp done"); end
      n_checks++; if (bad_read !== 0) begin n_fail++; $display("FAIL oor_color_read got %0d exp 0", bad_read); end
      n_checks++; if (busy_cnt !== 393) begin n_fail++; $display("FAIL oor_cycles got %0d exp 393", busy_cnt); end
      n_checks++; if (conflict !== 1'b0) begin n_fail++; $display("FAIL oor_conflict got %b exp 0", conflict); end
      n_checks++; if (uncolored !== 8'd32) begin n_fail++; $display("FAIL oor_uncol got %0d exp 32", uncolored); end
      n_checks++; if (mem[254] !== 8'h20) begin n_fail++; $display("FAIL oor_status got %h exp 20", mem[254]); end
   endtask

   task automatic test_abort();
      bit ok;
      load_image();
      cpu_write(8'd254, 8'h5A);
      start_pulse();
      repeat (20) tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got %b exp 0", busy); end
      n_checks++; if (uncolored !== 8'd2) begin n_fail++; $display("FAIL abort_partial got %0d exp 2", uncolored); end
      repeat (500) tick();
      n_checks++; if (done_seen !== 0) begin n_fail++; $display("FAIL abort_done got %0d exp 0", done_seen); end
      n_checks++; if (mem[254] !== 8'h5A) begin n_fail++; $display("FAIL abort_status got %h exp 5a", mem[254]); end
      // Rerun with stray start pulses while busy.
      start_pulse();
      repeat (5) tick();
      start = 1'b1; tick(); start = 1'b0;
      repeat (90) tick();
      start = 1'b1; tick(); start = 1'b0;
      wait_done(1000, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL rerun_timeout got no done exp done"); end
      n_checks++; if (busy_cnt !== 394) begin n_fail++; $display("FAIL rerun_cycles got %0d exp 394", busy_cnt); end
      n_checks++; if (uncolored !== 8'd33) begin n_fail++; $display("FAIL rerun_uncol got %0d exp 33", uncolored); end
      n_checks++; if (mem[254] !== 8'h21) begin n_fail++; $display("FAIL rerun_status got %h exp 21", mem[254]); end
      repeat (3) tick();
      n_checks++; if (busy !== 1'b0 || done_seen !== 1) begin n_fail++; $display("FAIL rerun_idle got busy=%b done_pulses=%0d exp 0/1", busy, done_seen); end
   endtask

   task automatic test_reset_midrun();
      load_image();
      cpu_write(8'd254, 8'h5A);
      start_pulse();
      repeat (30) tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mrst_busy got %b exp 0", busy); end
      n_checks++; if (uncolored !== 8'd0) begin n_fail++; $display("FAIL mrst_uncol got %0d exp 0", uncolored); end
      repeat (5) tick();
      n_checks++; if (mem[254] !== 8'h5A) begin n_fail++; $display("FAIL mrst_status got %h exp 5a", mem[254]); end
      n_checks++; if (done_seen !== 0) begin n_fail++; $display("FAIL mrst_done got %0d exp 0", done_seen); end
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; abort = 1'b0;
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 8'h00; cpu_wdata = 8'h00;
      mon_clr = 1'b1;
      test_reset();
      mon_clr = 1'b0;
      test_all_uncolored();
      test_conflict();
      test_cpu_stall();
      test_empty_list();
      test_out_of_range();
      test_abort();
      test_reset_midrun();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
